uart_pack_assembler: RTL and testbench
======================================

Name: uart_pack_assembler

Overview:
- Sits between the UART receiver and the multi-channel serial-output engine.
- Collects PACK_NUM consecutive UART bytes into one command pack and splits it into fields: control, low/high period, output pattern, frequency pattern.
- Emits the decoded fields with a one-cycle valid strobe to the serial-output engine.
- Discards a partial pack when the inter-byte gap exceeds a timeout, so a lost byte cannot misalign later packs.

Parameters:
- DATA_BIT, 32, width of the output pattern and of the frequency pattern (multiple of 8).
- PACK_NUM, (DATA_BIT/8)*2+3, bytes per pack; fixed by DATA_BIT, not independently overridable.
- TIMEOUT_CLK, 100_000, maximum idle clocks allowed between bytes of one pack (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- i_data  input  8  received UART byte.
- i_rx_done_tick  input  1  one-cycle strobe; i_data is valid in this cycle.
- o_channel  output  4  target channel index (control byte [3:0]).
- o_mode  output  2  control byte [7:6]: 00 load, 01 start, 10 stop, 11 reserved.
- o_low_period  output  8  clocks per bit, low-frequency mode.
- o_high_period  output  8  clocks per bit, high-frequency mode.
- o_out_pattern  output  DATA_BIT  serial output pattern.
- o_freq_pattern  output  DATA_BIT  per-bit frequency select pattern.
- o_pack_valid  output  1  one-cycle strobe; all field outputs are updated in this cycle.
- o_timeout_tick  output  1  one-cycle strobe; a partial pack was discarded.
- o_busy  output  1  high while a pack is partially received.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs return to 0 and the state machine returns to IDLE.
  - Byte counter, timeout counter and shift registers clear.
  - A pack in progress is lost; no strobe is issued for it.
- Pack byte order:
  - byte0: control (bits [5:4] ignored).
  - byte1: low period.
  - byte2: high period.
  - bytes 3..3+DATA_BIT/8-1: out_pattern, LSB byte first.
  - Remaining DATA_BIT/8 bytes: freq_pattern, LSB byte first.
- States:
  - IDLE: o_busy=0. On i_rx_done_tick, store byte0, set byte_cnt=1, clear timer, go to COLLECT.
  - COLLECT: o_busy=1.
    - On i_rx_done_tick: store the byte at index byte_cnt, byte_cnt++, clear timer.
    - If the byte stored is index PACK_NUM-1, go to DONE.
    - With no byte in a cycle: timer++.
    - Timer reaching TIMEOUT_CLK-1 with no byte in that cycle: pulse o_timeout_tick for one cycle, clear counters, go to IDLE.
  - DONE (exactly one cycle): copy the staging registers to the field outputs, pulse o_pack_valid, o_busy=0, go to IDLE.
    - An i_rx_done_tick arriving in the DONE cycle is accepted as byte0 of the next pack (go to COLLECT, byte_cnt=1).
- Latency: o_pack_valid is high in the cycle after the clock edge that samples the final byte's i_rx_done_tick.
- Field outputs are registered and hold their values until the next o_pack_valid. A timeout leaves them unchanged.
- Simultaneous byte and timeout expiry in the same cycle: the byte wins and the timer clears.
- Control bytes with mode 11 still produce o_pack_valid; rejecting them is the consumer's job.
- No back-pressure: the consumer must accept o_pack_valid in a single cycle.
- Timer width is clog2(TIMEOUT_CLK). The timer saturates and never wraps.
- byte_cnt width is clog2(PACK_NUM+1).

Test Plan:
- Reset, then send 11 bytes 0x45,0x14,0x05,0x78,0x56,0x34,0x12,0xEF,0xCD,0xAB,0x89 spaced 50 clks -> o_channel=5, o_mode=01, o_low_period=0x14, o_high_period=0x05, o_out_pattern=0x12345678, o_freq_pattern=0x89ABCDEF; o_pack_valid high exactly one cycle after the 11th tick; o_busy low afterwards.
- Send 4 bytes, idle TIMEOUT_CLK clks, then a full valid pack -> one o_timeout_tick; fields unchanged by the partial pack; the following pack decodes correctly.
- Place a byte on the exact cycle the timer hits TIMEOUT_CLK-1 -> no o_timeout_tick; pack completes normally.
- Send two packs back-to-back, with byte0 of pack 2 arriving in the DONE cycle -> two o_pack_valid pulses, both decoded correctly.
- Assert rst mid-pack (after 6 bytes), release, send a full pack -> outputs 0 during reset; no o_pack_valid for the aborted pack; the new pack decodes correctly.
- Send a pack with control byte 0xFF -> o_mode=11, o_channel=15, o_pack_valid still pulses.

Source files
------------

// File: rtl/uart_pack_assembler.sv
// uart_pack_assembler
//   Collects PACK_NUM consecutive UART bytes into one command pack and emits the
//   decoded fields with a single-cycle valid strobe. A partial pack is dropped
//   when the gap between two of its bytes exceeds TIMEOUT_CLK clocks.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   i_data            : received UART byte
//   i_rx_done_tick    : one-cycle strobe, i_data valid in this cycle
//   o_channel         : control byte [3:0]
//   o_mode            : control byte [7:6] (00 load, 01 start, 10 stop, 11 reserved)
//   o_low_period      : clocks per bit, low-frequency mode
//   o_high_period     : clocks per bit, high-frequency mode
//   o_out_pattern     : serial output pattern
//   o_freq_pattern    : per-bit frequency select pattern
//   o_pack_valid      : one-cycle strobe, field outputs updated this cycle
//   o_timeout_tick    : one-cycle strobe, a partial pack was discarded
//   o_busy            : high while a pack is partially received
module uart_pack_assembler #(
  parameter int unsigned DATA_BIT    = 32,
  parameter int unsigned TIMEOUT_CLK = 100_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  output logic [3:0]          o_channel,
  output logic [1:0]          o_mode,
  output logic [7:0]          o_low_period,
  output logic [7:0]          o_high_period,
  output logic [DATA_BIT-1:0] o_out_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_pack_valid,
  output logic                o_timeout_tick,
  output logic                o_busy
);

  localparam int unsigned PACK_NUM = (DATA_BIT / 8) * 2 + 3;
  localparam int unsigned PACK_W   = PACK_NUM * 8;
  localparam int unsigned TMR_W    = $clog2(TIMEOUT_CLK);
  localparam int unsigned CNT_W    = $clog2(PACK_NUM + 1);
  localparam int unsigned OUT_LSB  = 24;
  localparam int unsigned FREQ_LSB = 24 + DATA_BIT;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLK - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [PACK_W-1:0]   sr_q, sr_d;
  logic [3:0]          channel_q, channel_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          low_q, low_d;
  logic [7:0]          high_q, high_d;
  logic [DATA_BIT-1:0] out_q, out_d;
  logic [DATA_BIT-1:0] freq_q, freq_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;

  // Byte 0 ends up in the low byte after a full pack has been shifted in from the top.
  logic [PACK_W-1:0]   sr_shift;
  assign sr_shift = {i_data, sr_q[PACK_W-1:8]};

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      sr_q      <= '0;
      channel_q <= '0;
      mode_q    <= '0;
      low_q     <= '0;
      high_q    <= '0;
      out_q     <= '0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      sr_q      <= sr_d;
      channel_q <= channel_d;
      mode_q    <= mode_d;
      low_q     <= low_d;
      high_q    <= high_d;
      out_q     <= out_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    sr_d      = sr_q;
    channel_d = channel_q;
    mode_d    = mode_q;
    low_d     = low_q;
    high_d    = high_q;
    out_d     = out_q;
    freq_d    = freq_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for incoming bytes so back-to-back packs are accepted.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tmr_d   = '0;
        if (i_rx_done_tick) begin
          sr_d    = sr_shift;
          cnt_d   = CNT_W'(1);
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (i_rx_done_tick) begin
          // A byte always wins over a simultaneous timer expiry.
          sr_d  = sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          tmr_d = '0;
          if (cnt_q == CNT_LAST) begin
            // Fields load on the final-byte edge so they are valid in the DONE cycle.
            state_d   = S_DONE;
            cnt_d     = '0;
            valid_d   = 1'b1;
            channel_d = sr_shift[3:0];
            mode_d    = sr_shift[7:6];
            low_d     = sr_shift[15:8];
            high_d    = sr_shift[23:16];
            out_d     = sr_shift[OUT_LSB +: DATA_BIT];
            freq_d    = sr_shift[FREQ_LSB +: DATA_BIT];
          end
        end else if (tmr_q == TMR_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          tmr_d     = '0;
          timeout_d = 1'b1;
        end else begin
          // Leaving at TMR_LAST keeps the timer from ever wrapping.
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase

    busy_d = (state_d == S_COLLECT);
  end

  assign o_channel      = channel_q;
  assign o_mode         = mode_q;
  assign o_low_period   = low_q;
  assign o_high_period  = high_q;
  assign o_out_pattern  = out_q;
  assign o_freq_pattern = freq_q;
  assign o_pack_valid   = valid_q;
  assign o_timeout_tick = timeout_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_pack_assembler.sv
// tb_uart_pack_assembler
//   Directed bench for uart_pack_assembler. Expected packs are pushed to a
//   scoreboard queue when their last byte is driven and compared when the DUT
//   strobes o_pack_valid.
module tb_uart_pack_assembler;

  localparam int unsigned DB = 32;
  localparam int unsigned TO = 64;
  localparam int unsigned PN = (DB / 8) * 2 + 3;

  typedef struct packed {
    logic [3:0]    ch;
    logic [1:0]    mode;
    logic [7:0]    lo;
    logic [7:0]    hi;
    logic [DB-1:0] outp;
    logic [DB-1:0] freq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data;
  logic          tick;
  logic [3:0]    o_channel;
  logic [1:0]    o_mode;
  logic [7:0]    o_low_period;
  logic [7:0]    o_high_period;
  logic [DB-1:0] o_out_pattern;
  logic [DB-1:0] o_freq_pattern;
  logic          o_pack_valid;
  logic          o_timeout_tick;
  logic          o_busy;

  int   checks   = 0;
  int   failures = 0;
  int   vcnt     = 0;
  int   tocnt    = 0;
  exp_t sb_q[$];
  logic [7:0] pk [PN];

  uart_pack_assembler #(.DATA_BIT(DB), .TIMEOUT_CLK(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_data         (data),
    .i_rx_done_tick (tick),
    .o_channel      (o_channel),
    .o_mode         (o_mode),
    .o_low_period   (o_low_period),
    .o_high_period  (o_high_period),
    .o_out_pattern  (o_out_pattern),
    .o_freq_pattern (o_freq_pattern),
    .o_pack_valid   (o_pack_valid),
    .o_timeout_tick (o_timeout_tick),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode of the pack currently in pk.
  function automatic exp_t model();
    exp_t e;
    e.ch   = pk[0][3:0];
    e.mode = pk[0][7:6];
    e.lo   = pk[1];
    e.hi   = pk[2];
    for (int i = 0; i < int'(DB / 8); i++) begin
      e.outp[8*i +: 8] = pk[3 + i];
      e.freq[8*i +: 8] = pk[3 + int'(DB / 8) + i];
    end
    return e;
  endfunction

  // Drive one byte after pre idle cycles; returns 1ns after the sampling edge.
  task automatic send_byte(input logic [7:0] b, input int pre);
    repeat (pre) @(posedge clk);
    #1;
    data = b;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Send pk[0..n-1]; byte long_idx waits exactly TO-1 idle cycles.
  task automatic send_pack(input int n, input int first_pre, input int gap,
                           input int long_idx, input bit push);
    for (int i = 0; i < n; i++) begin
      if (push && i == int'(PN) - 1) sb_q.push_back(model());
      send_byte(pk[i], (i == long_idx) ? int'(TO) - 1 :
                       (i == 0) ? first_pre : gap);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fields"}, {o_channel, o_mode, o_low_period, o_high_period,
                             o_out_pattern[15:0], o_freq_pattern[15:0]}, 64'h0);
    check({tag, "_pat_hi"}, {o_out_pattern[DB-1:16], o_freq_pattern[DB-1:16]}, 64'h0);
    check({tag, "_strobes"}, {61'h0, o_pack_valid, o_timeout_tick, o_busy}, 64'h0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (o_timeout_tick === 1'b1) tocnt++;
      if (o_pack_valid === 1'b1) begin
        exp_t e;
        vcnt++;
        check("sb_nonempty", 64'(sb_q.size() > 0), 64'h1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("channel",   64'(o_channel),      64'(e.ch));
          check("mode",      64'(o_mode),         64'(e.mode));
          check("low",       64'(o_low_period),   64'(e.lo));
          check("high",      64'(o_high_period),  64'(e.hi));
          check("out_pat",   64'(o_out_pattern),  64'(e.outp));
          check("freq_pat",  64'(o_freq_pattern), 64'(e.freq));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int t0;
    rst  = 1'b1;
    data = 8'h00;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic pack, 50 clocks between bytes
    pk = '{8'h45, 8'h14, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    v0 = vcnt;
    send_pack(PN, 49, 49, -1, 1'b1);
    @(negedge clk);
    check("t1_valid_latency", 64'(o_pack_valid), 64'h1);
    check("t1_busy_done", 64'(o_busy), 64'h0);
    check("t1_direct_fields", {o_channel, o_mode, o_low_period, o_high_period, o_out_pattern},
          {4'h5, 2'b01, 8'h14, 8'h05, 32'h12345678});
    check("t1_direct_freq", 64'(o_freq_pattern), 64'h89ABCDEF);
    @(negedge clk);
    check("t1_valid_one_cycle", 64'(o_pack_valid), 64'h0);
    check("t1_busy_after", 64'(o_busy), 64'h0);
    check("t1_vcnt", 64'(vcnt - v0), 64'h1);

    // Partial pack then timeout; fields must survive
    pk = '{8'h92, 8'h21, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    t0 = tocnt;
    send_pack(4, 3, 5, -1, 1'b0);
    @(negedge clk);
    check("t2_busy_partial", 64'(o_busy), 64'h1);
    repeat (TO + 5) @(posedge clk);
    @(negedge clk);
    check("t2_timeout_count", 64'(tocnt - t0), 64'h1);
    check("t2_busy_idle", 64'(o_busy), 64'h0);
    check("t2_fields_held", {o_low_period, o_high_period, o_out_pattern}, {8'h14, 8'h05, 32'h12345678});
    @(posedge clk);
    #1;
    v0 = vcnt;
    send_pack(PN, 2, 3, -1, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_vcnt", 64'(vcnt - v0), 64'h1);

    // Byte lands on the exact cycle the timer reaches TO-1
    pk = '{8'h83, 8'h40, 8'h08, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
    t0 = tocnt;
    v0 = vcnt;
    send_pack(PN, 2, 2, 5, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_no_timeout", 64'(tocnt - t0), 64'h0);
    check("t3_vcnt", 64'(vcnt - v0), 64'h1);

    // Back-to-back packs, byte0 of the second pack in the DONE cycle
    v0 = vcnt;
    pk = '{8'h07, 8'h0A, 8'h0B, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_pack(PN, 2, 1, -1, 1'b1);
    pk = '{8'h8C, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h99, 8'h66, 8'h5A, 8'hA5};
    send_pack(PN, 0, 1, -1, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_vcnt", 64'(vcnt - v0), 64'h2);

    // Reset in the middle of a pack
    pk = '{8'h4E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    v0 = vcnt;
    send_pack(6, 2, 2, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_zero("t5_in_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pk = '{8'h41, 8'h10, 8'h20, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
    send_pack(PN, 2, 2, -1, 1'b1);
    repeat (3) @(negedge clk);
    check("t5_vcnt", 64'(vcnt - v0), 64'h1);

    // Reserved mode still produces a valid strobe
    pk = '{8'hFF, 8'h33, 8'h44, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    v0 = vcnt;
    send_pack(PN, 2, 2, -1, 1'b1);
    @(negedge clk);
    check("t6_valid", 64'(o_pack_valid), 64'h1);
    check("t6_mode_ch", {o_mode, o_channel}, 64'h3F);
    repeat (3) @(negedge clk);
    check("t6_vcnt", 64'(vcnt - v0), 64'h1);

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
